// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter for a shared single-port
// synchronous memory with 1-cycle registered read data.
// Port A is instruction fetch, port B is load/store. Grant is combinational.
// The owner of each read is tagged in a register so that the response
// returns to the port that issued it.
// Optional build macro MEM_ARB_PERF_EN adds saturating performance counters
// (a_grant_cnt, b_grant_cnt, conflict_cnt).
module mem_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ack,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ack,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_out
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0]  a_grant_cnt,
    output logic [CNT_WIDTH-1:0]  b_grant_cnt,
    output logic [CNT_WIDTH-1:0]  conflict_cnt
`endif
);

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_A    = 2'd1,
        OWNER_B    = 2'd2
    } owner_e;

    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } last_e;

    logic                  grant_a_s;
    logic                  grant_b_s;
    last_e                 last_grant_r;
    owner_e                rd_owner_r;
    logic [ADDR_WIDTH-1:0] addr_hold_r;
    logic [DATA_WIDTH-1:0] data_hold_r;

    // Round-robin grant; nothing is granted while reset is asserted.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (!rst_n) begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end else if (a_req && b_req) begin
            if (last_grant_r == LAST_B) begin
                grant_a_s = 1'b1;
            end else begin
                grant_b_s = 1'b1;
            end
        end else if (a_req) begin
            grant_a_s = 1'b1;
        end else if (b_req) begin
            grant_b_s = 1'b1;
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    // Memory bus mux; idle cycles replay the last granted address/data.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = addr_hold_r;
        mem_data = data_hold_r;
        if (grant_a_s) begin
            mem_we   = a_we;
            mem_addr = a_addr;
            mem_data = a_wdata;
        end else if (grant_b_s) begin
            mem_we   = b_we;
            mem_addr = b_addr;
            mem_data = b_wdata;
        end else begin
            mem_we   = 1'b0;
            mem_addr = addr_hold_r;
            mem_data = data_hold_r;
        end
    end

    assign a_ack    = grant_a_s;
    assign b_ack    = grant_b_s;
    assign a_rdata  = mem_out;
    assign b_rdata  = mem_out;
    assign a_rvalid = (rd_owner_r == OWNER_A);
    assign b_rvalid = (rd_owner_r == OWNER_B);

    // Arbitration history, bus hold registers and read-response owner tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= LAST_B;
            rd_owner_r   <= OWNER_NONE;
            addr_hold_r  <= {ADDR_WIDTH{1'b0}};
            data_hold_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            if (grant_a_s) begin
                last_grant_r <= LAST_A;
            end else if (grant_b_s) begin
                last_grant_r <= LAST_B;
            end
            if (grant_a_s || grant_b_s) begin
                addr_hold_r <= mem_addr;
                data_hold_r <= mem_data;
            end
            if (grant_a_s && !a_we) begin
                rd_owner_r <= OWNER_A;
            end else if (grant_b_s && !b_we) begin
                rd_owner_r <= OWNER_B;
            end else begin
                rd_owner_r <= OWNER_NONE;
            end
        end
    end

`ifdef MEM_ARB_PERF_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Saturating grant and conflict counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_grant_cnt  <= {CNT_WIDTH{1'b0}};
            b_grant_cnt  <= {CNT_WIDTH{1'b0}};
            conflict_cnt <= {CNT_WIDTH{1'b0}};
        end else begin
            if (grant_a_s && (a_grant_cnt != CNT_MAX)) begin
                a_grant_cnt <= a_grant_cnt + CNT_ONE;
            end
            if (grant_b_s && (b_grant_cnt != CNT_MAX)) begin
                b_grant_cnt <= b_grant_cnt + CNT_ONE;
            end
            if (a_req && b_req && (conflict_cnt != CNT_MAX)) begin
                conflict_cnt <= conflict_cnt + CNT_ONE;
            end
        end
    end
`endif

endmodule
